// File: rtl/mem_stage.sv
// Memory stage of the pipeline: consumes the registered EX outputs, performs the
// data-memory access over a req/ack bus (word or byte lanes) and drives the
// MEM/WB registers.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   we                      pipeline write enable from the hazard unit
//   is_branch, alu_zero,    branch resolution inputs from EX
//   pc_branch
//   mem_read, mem_write,    memory request and its width (0 = word, 1 = byte)
//   mem_type
//   mem_to_reg, reg_write   writeback controls
//   alu_out, data_t,        effective address / ALU result, store data,
//   reg_addr                destination register
//   branch_taken/_target    combinational branch resolution
//   stall                   holds upstream stages while an access is in flight
//   reg/data/write_probe    forwarding probe of the current EX/MEM contents
//   dmem_*                  data-memory bus (req/we/addr/be/wdata out, rdata/ack in)
//   wb_*                    MEM/WB pipeline registers
//   bus_err, addr_err       sticky error flags (ack timeout, misaligned word access)
module mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TCW     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        is_branch,
  input  logic        alu_zero,
  input  logic [31:0] pc_branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_type,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_t,
  input  logic [4:0]  reg_addr,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [4:0]  reg_probe,
  output logic [31:0] data_probe,
  output logic        write_probe,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data,
  output logic [4:0]  wb_reg_addr,
  output logic        bus_err,
  output logic        addr_err
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic [TCW-1:0] cnt_q;
  logic [31:0]    cap_q;
  // Shape of the in-flight access, kept so read formatting does not depend on
  // upstream holding its outputs.
  logic           op_byte_q, op_load_q;
  logic [1:0]     op_lane_q;

  logic        mem_op, aligned, timeout_hit;
  logic        start, commit;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  rd_byte;
  logic [31:0] rd_fmt;

  assign mem_op      = mem_read | mem_write;
  assign aligned     = mem_type | (alu_out[1:0] == 2'b00);
  assign timeout_hit = (cnt_q == TCW'(TIMEOUT - 1));

  assign req_be    = mem_type ? (4'b0001 << alu_out[1:0]) : 4'b1111;
  assign req_wdata = mem_type ? {4{data_t[7:0]}} : data_t;

  // Little-endian lane select; stores capture zero.
  assign rd_byte = dmem_rdata[{op_lane_q, 3'b000} +: 8];
  assign rd_fmt  = !op_load_q ? 32'h0 :
                   op_byte_q  ? {{24{rd_byte[7]}}, rd_byte} : dmem_rdata;

  assign branch_taken  = is_branch & alu_zero;
  assign branch_target = pc_branch;

  assign reg_probe   = reg_addr;
  assign data_probe  = alu_out;
  assign write_probe = reg_write & ~mem_to_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && aligned) begin
          // we is ignored here: the bus access always launches.
          state_d = StWait;
          start   = 1'b1;
          stall   = 1'b1;
        end else if (we) begin
          commit = 1'b1;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (dmem_ack || timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (we) begin
          state_d = StIdle;
          commit  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Upstream must see stall released as soon as reset is asserted.
    stall = stall & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      cap_q         <= '0;
      op_byte_q     <= 1'b0;
      op_load_q     <= 1'b0;
      op_lane_q     <= 2'b00;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_alu_out    <= '0;
      wb_mem_data   <= '0;
      wb_reg_addr   <= '0;
      bus_err       <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_write;
        dmem_addr  <= {alu_out[31:2], 2'b00};
        dmem_be    <= req_be;
        dmem_wdata <= req_wdata;
        cnt_q      <= '0;
        op_byte_q  <= mem_type;
        op_load_q  <= mem_read;
        op_lane_q  <= alu_out[1:0];
      end

      if (state_q == StWait) begin
        if (dmem_ack) begin
          // Ack wins over a simultaneous timeout.
          cap_q    <= rd_fmt;
          dmem_req <= 1'b0;
        end else if (timeout_hit) begin
          bus_err  <= 1'b1;
          cap_q    <= '0;
          dmem_req <= 1'b0;
        end else begin
          cnt_q <= cnt_q + TCW'(1);
        end
      end

      if ((state_q == StIdle) && mem_op && !aligned) begin
        addr_err <= 1'b1;
      end

      if (commit) begin
        wb_mem_to_reg <= mem_to_reg;
        // A commit from IDLE with mem_op set is a rejected misaligned access.
        wb_reg_write  <= reg_write & ~((state_q == StIdle) & mem_op);
        wb_alu_out    <= alu_out;
        wb_reg_addr   <= reg_addr;
        wb_mem_data   <= (state_q == StDone) ? cap_q : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        is_branch = 1'b0, alu_zero = 1'b0;
  logic [31:0] pc_branch = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_type = 1'b0;
  logic        mem_to_reg = 1'b0, reg_write = 1'b0;
  logic [31:0] alu_out = '0, data_t = '0;
  logic [4:0]  reg_addr = '0;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [4:0]  reg_probe;
  logic [31:0] data_probe;
  logic        write_probe;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_mem_to_reg, wb_reg_write;
  logic [31:0] wb_alu_out, wb_mem_data;
  logic [4:0]  wb_reg_addr;
  logic        bus_err, addr_err;

  mem_stage #(.TIMEOUT(TO), .TCW(3)) dut (
    .clk(clk), .reset(reset), .we(we),
    .is_branch(is_branch), .alu_zero(alu_zero), .pc_branch(pc_branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_out(alu_out), .data_t(data_t), .reg_addr(reg_addr),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .reg_probe(reg_probe), .data_probe(data_probe), .write_probe(write_probe),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_reg_addr(wb_reg_addr),
    .bus_err(bus_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [4:0]  ra;
    logic        berr;
    logic        aerr;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];

  int n_vec = 0;
  int n_err = 0;
  logic exp_berr = 1'b0, exp_aerr = 1'b0;
  int plan_delay = 0;
  logic [31:0] plan_rdata = '0;
  logic commit_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus responder: acks after plan_delay WAIT cycles and checks the request.
  int wcnt = 0;
  bus_t rb;
  always @(negedge clk) begin
    dmem_rdata = plan_rdata;
    if (dmem_req) begin
      if (wcnt == 0) begin
        if (bus_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr);
        end else begin
          rb = bus_q.pop_front();
          chk("dmem_addr", dmem_addr, rb.addr);
          chk("dmem_be", 32'(dmem_be), 32'(rb.be));
          chk("dmem_wdata", dmem_wdata, rb.wdata);
          chk("dmem_we", 32'(dmem_we), 32'(rb.we));
        end
      end
      dmem_ack = (wcnt == plan_delay);
      wcnt++;
    end else begin
      dmem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: a commit happens on an edge where stall=0 and we=1 just before it.
  wb_t me;
  always @(negedge clk) begin
    #2;
    commit_pending = reset && !stall && we;
  end

  always @(posedge clk) begin
    #1;
    if (commit_pending) begin
      if (wb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_commit: got wb_alu_out %h expected no commit", wb_alu_out);
      end else begin
        me = wb_q.pop_front();
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(me.m2r));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(me.rw));
        chk("wb_alu_out", wb_alu_out, me.alu);
        chk("wb_mem_data", wb_mem_data, me.mdata);
        chk("wb_reg_addr", 32'(wb_reg_addr), 32'(me.ra));
        chk("bus_err", 32'(bus_err), 32'(me.berr));
        chk("addr_err", 32'(addr_err), 32'(me.aerr));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    we = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    wb_q.delete(); bus_q.delete();
    exp_berr = 1'b0; exp_aerr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issues one instruction (called right at a falling edge) and returns at the
  // falling edge after it commits.
  task automatic run_op(input logic rd, input logic wr, input logic byt, input logic m2r,
                        input logic rw, input logic [31:0] alu, input logic [31:0] dt,
                        input logic [4:0] ra, input int delay, input logic [31:0] rdata);
    wb_t  e;
    bus_t b;
    int   exp_stalls, stalls, guard, hold, lane, sv;
    logic ib, az;
    logic [31:0] pcb;
    ib = 1'($urandom); az = 1'($urandom); pcb = $urandom;
    mem_read = rd; mem_write = wr; mem_type = byt; mem_to_reg = m2r; reg_write = rw;
    alu_out = alu; data_t = dt; reg_addr = ra; we = 1'b1;
    is_branch = ib; alu_zero = az; pc_branch = pcb;
    plan_delay = delay; plan_rdata = rdata;

    e.m2r = m2r; e.rw = rw; e.alu = alu; e.ra = ra; e.mdata = 32'h0;
    exp_stalls = 0;
    if ((rd || wr) && !byt && (alu % 4 != 0)) begin
      e.rw = 1'b0;
      exp_aerr = 1'b1;
    end else if (rd || wr) begin
      lane    = int'(alu % 4);
      b.addr  = alu - (alu % 4);
      b.be    = byt ? 4'(32'd1 << lane) : 4'hF;
      b.wdata = byt ? {4{dt[7:0]}} : dt;
      b.we    = wr;
      bus_q.push_back(b);
      if (delay < TO) begin
        exp_stalls = delay + 2;
        if (rd && byt) begin
          sv = int'((rdata >> (8 * lane)) & 32'hFF);
          if (sv > 127) sv = sv - 256;
          e.mdata = 32'(sv);
        end else if (rd) begin
          e.mdata = rdata;
        end
      end else begin
        exp_stalls = TO + 1;
        exp_berr = 1'b1;
      end
    end
    e.berr = exp_berr; e.aerr = exp_aerr;
    wb_q.push_back(e);

    #1;
    chk("branch_taken", 32'(branch_taken), 32'(ib & az));
    chk("branch_target", branch_target, pcb);
    chk("reg_probe", 32'(reg_probe), 32'(ra));
    chk("data_probe", data_probe, alu);
    chk("write_probe", 32'(write_probe), 32'(rw & ~m2r));

    stalls = 0; guard = 0;
    while (stall && guard < 64) begin
      we = 1'($urandom);  // ignored while stalled
      stalls++; guard++;
      @(negedge clk); #1;
    end
    if (guard >= 64) begin
      n_vec++; n_err++;
      $display("FAIL stall_stuck: got stall=1 for %0d cycles expected release", guard);
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));

    hold = $urandom_range(0, 2);
    repeat (hold) begin
      we = 1'b0;
      @(negedge clk); #1;
    end
    we = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] r_alu;
  int kind;

  initial begin
    #3;
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_dmem_be", 32'(dmem_be), 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_wb_alu_out", wb_alu_out, 0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    do_reset();

    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd7, 0, 32'h0);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h203, 32'hA5, 5'd0, 0, 32'h0);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h203, 32'h0, 5'd9, 0, 32'h80000000);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd4, 0, 32'h0);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd5, TO + 2, 32'h11111111);
    do_reset();
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h304, 32'h0, 5'd6, TO - 1, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) begin
      kind  = $urandom_range(0, 2);
      r_alu = $urandom;
      if ($urandom_range(0, 1) == 1) r_alu[1:0] = 2'b00;
      run_op(kind == 1, kind == 2, 1'($urandom), 1'($urandom), 1'($urandom), r_alu, $urandom,
             5'($urandom), $urandom_range(0, TO + 1), $urandom);
    end

    we = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("wb_queue_drained", 32'(wb_q.size()), 0);
    chk("bus_queue_drained", 32'(bus_q.size()), 0);

    // Reset in the middle of a bus wait, plus same-cycle branch resolution.
    mem_read = 1'b1; mem_type = 1'b0; alu_out = 32'h400; reg_write = 1'b1;
    mem_to_reg = 1'b1; we = 1'b1; plan_delay = 20;
    bus_q.push_back('{addr: 32'h400, wdata: data_t, be: 4'hF, we: 1'b0});
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wait_req_high", 32'(dmem_req), 1);
    is_branch = 1'b1; alu_zero = 1'b1; pc_branch = 32'h40;
    reset = 1'b0;
    #1;
    chk("midwait_dmem_req", 32'(dmem_req), 0);
    chk("midwait_stall", 32'(stall), 0);
    chk("midwait_wb_alu_out", wb_alu_out, 0);
    chk("midwait_wb_mem_data", wb_mem_data, 0);
    chk("midwait_wb_reg_write", 32'(wb_reg_write), 0);
    chk("midwait_wb_reg_addr", 32'(wb_reg_addr), 0);
    chk("branch_taken_dir", 32'(branch_taken), 1);
    chk("branch_target_dir", branch_target, 32'h40);
    do_reset();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1);
  end

endmodule
